// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game sequencer.
package hangman_pkg;

  localparam int MAX_LEN_DEF = 7;
  localparam int CHAR_W_DEF  = 7;

  localparam logic [6:0] ASCII_A = 7'h41;
  localparam logic [6:0] ASCII_Z = 7'h5A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    EVAL  = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } state_e;

endpackage

// File: rtl/letter_match_vec.sv
// Parallel compare of one guessed letter against every word position, masked to the used length.
module letter_match_vec #(
  parameter int MAX_LEN = 7,
  parameter int CHAR_W  = 7,
  parameter int LEN_W   = 3
) (
  input  logic [MAX_LEN*CHAR_W-1:0] word_i,
  input  logic [CHAR_W-1:0]         guess_i,
  input  logic [LEN_W-1:0]          len_i,
  output logic [MAX_LEN-1:0]        match_o,
  output logic [MAX_LEN-1:0]        used_o
);

  always_comb begin
    match_o = '0;
    used_o  = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      used_o[k]  = (k < int'(len_i));
      match_o[k] = (word_i[k*CHAR_W +: CHAR_W] == guess_i) && (k < int'(len_i));
    end
  end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman sequencer: requests/loads a word, evaluates one guess per three cycles, tracks mask and lives.
// Define HANGMAN_DUP_FILTER_EN to keep a guessed-letter history and reject repeated letters.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int CHAR_W   = CHAR_W_DEF,
  parameter int LIVES    = 7,
  localparam int LIFE_W  = $clog2(LIVES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_game,
  output logic                      word_req,
  input  logic                      word_valid,
  input  logic [MAX_LEN*CHAR_W-1:0] word_i,
  input  logic [2:0]                word_len,
  input  logic                      guess_valid,
  input  logic [CHAR_W-1:0]         guess_char,
  output logic                      guess_ready,
  output logic                      guess_reject,
  output logic [MAX_LEN-1:0]        reveal_mask,
  output logic [LIFE_W-1:0]         lives,
  output logic                      win,
  output logic                      lose
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e                    state_q, state_d;
  logic [MAX_LEN-1:0]        mask_q, mask_d;
  logic [LIFE_W-1:0]         lives_q, lives_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      word_req_q, word_req_d;
  logic                      reject_q, reject_d;
  logic [MAX_LEN*CHAR_W-1:0] word_q;
  logic [CHAR_W-1:0]         guess_q;
  logic                      load_word;
  logic [MAX_LEN-1:0]        match;
  logic [MAX_LEN-1:0]        used;
  logic                      legal;
  logic                      dup;
  logic                      accept;

  letter_match_vec #(
    .MAX_LEN (MAX_LEN),
    .CHAR_W  (CHAR_W),
    .LEN_W   (LEN_W)
  ) u_match (
    .word_i  (word_q),
    .guess_i (guess_q),
    .len_i   (len_q),
    .match_o (match),
    .used_o  (used)
  );

  assign legal  = (guess_q >= CHAR_W'(ASCII_A)) && (guess_q <= CHAR_W'(ASCII_Z));
  assign accept = legal && !dup;

`ifdef HANGMAN_DUP_FILTER_EN
  logic [25:0] hist_q;
  logic [4:0]  letter_idx;

  assign letter_idx = 5'(guess_q - CHAR_W'(ASCII_A));
  assign dup        = legal && hist_q[letter_idx];

  // History follows the word: cleared on load, marked only by accepted guesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else if (load_word) begin
      hist_q <= '0;
    end else if ((state_q == CHECK) && !new_game && accept) begin
      hist_q[letter_idx] <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    lives_d    = lives_q;
    len_d      = len_q;
    word_req_d = 1'b0;
    reject_d   = 1'b0;
    load_word  = 1'b0;
    // A restart overrides everything, including a guess in flight.
    if (new_game) begin
      state_d    = LOAD;
      word_req_d = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (word_valid) begin
            if (word_len == 3'd0) begin
              word_req_d = 1'b1;
            end else begin
              load_word = 1'b1;
              len_d     = (int'(word_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(word_len);
              mask_d    = '0;
              lives_d   = LIFE_W'(LIVES);
              state_d   = PLAY;
            end
          end
        end
        PLAY: begin
          if (guess_valid) state_d = CHECK;
        end
        CHECK: begin
          if (!accept) begin
            reject_d = 1'b1;
            state_d  = PLAY;
          end else begin
            mask_d = mask_q | match;
            if ((match == '0) && (lives_q != '0)) lives_d = lives_q - LIFE_W'(1);
            state_d = EVAL;
          end
        end
        EVAL: begin
          if (&(mask_q | ~used))  state_d = WIN;
          else if (lives_q == '0) state_d = LOSE;
          else                    state_d = PLAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      lives_q    <= LIFE_W'(LIVES);
      len_q      <= '0;
      word_req_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      lives_q    <= lives_d;
      len_q      <= len_d;
      word_req_q <= word_req_d;
      reject_q   <= reject_d;
    end
  end

  // Word and guess are pure data; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (load_word) word_q <= word_i;
    if ((state_q == PLAY) && guess_valid) guess_q <= guess_char;
  end

  assign word_req     = word_req_q;
  assign guess_reject = reject_q;
  assign reveal_mask  = mask_q;
  assign lives        = lives_q;
  assign guess_ready  = (state_q == PLAY);
  assign win          = (state_q == WIN);
  assign lose         = (state_q == LOSE);

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Directed testbench for hangman_game_ctrl with hand-computed expectations.
module tb_hangman_game_ctrl;

  logic        clk;
  logic        reset;
  logic        new_game;
  logic        word_req;
  logic        word_valid;
  logic [48:0] word_i;
  logic [2:0]  word_len;
  logic        guess_valid;
  logic [6:0]  guess_char;
  logic        guess_ready;
  logic        guess_reject;
  logic [6:0]  reveal_mask;
  logic [2:0]  lives;
  logic        win;
  logic        lose;

  int checks = 0;
  int fails  = 0;

  hangman_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .word_req     (word_req),
    .word_valid   (word_valid),
    .word_i       (word_i),
    .word_len     (word_len),
    .guess_valid  (guess_valid),
    .guess_char   (guess_char),
    .guess_ready  (guess_ready),
    .guess_reject (guess_reject),
    .reveal_mask  (reveal_mask),
    .lives        (lives),
    .win          (win),
    .lose         (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [48:0] mkword(input string s);
    logic [48:0] w;
    byte         b;
    w = '0;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      w[i*7 +: 7] = b[6:0];
    end
    return w;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic load_word(input string s, input logic [2:0] l);
    new_game = 1'b1;
    @(negedge clk);
    new_game   = 1'b0;
    word_valid = 1'b1;
    word_i     = mkword(s);
    word_len   = l;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic do_guess(input logic [6:0] c);
    guess_valid = 1'b1;
    guess_char  = c;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (reveal_mask !== 7'h00) begin fails++; $display("FAIL rst_mask: got %h want 00", reveal_mask); end
    checks++; if (lives !== 3'd7) begin fails++; $display("FAIL rst_lives: got %0d want 7", lives); end
    checks++; if ({win, lose, guess_ready, word_req, guess_reject} !== 5'b0) begin
      fails++; $display("FAIL rst_flags: got %b want 00000", {win, lose, guess_ready, word_req, guess_reject}); end
    reset       = 1'b0;
    guess_valid = 1'b1;
    guess_char  = 7'h41;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    checks++; if (guess_ready !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b want 0", guess_ready); end
    checks++; if (reveal_mask !== 7'h00) begin fails++; $display("FAIL idle_mask: got %h want 00", reveal_mask); end
  endtask

  task automatic test_hit();
    load_word("HANGMAN", 3'd7);
    checks++; if (guess_ready !== 1'b1) begin fails++; $display("FAIL hit_ready0: got %b want 1", guess_ready); end
    guess_valid = 1'b1;
    guess_char  = 7'h41;
    @(negedge clk);
    guess_valid = 1'b0;
    checks++; if (guess_ready !== 1'b0) begin fails++; $display("FAIL hit_check_ready: got %b want 0", guess_ready); end
    @(negedge clk);
    checks++; if (reveal_mask !== 7'b0100010) begin fails++; $display("FAIL hit_mask: got %b want 0100010", reveal_mask); end
    checks++; if (lives !== 3'd7) begin fails++; $display("FAIL hit_lives: got %0d want 7", lives); end
    @(negedge clk);
    checks++; if (guess_ready !== 1'b1) begin fails++; $display("FAIL hit_ready_e2: got %b want 1", guess_ready); end
  endtask

  task automatic test_miss_lose();
    logic [6:0] misses [7];
    misses = '{7'h5A, 7'h42, 7'h43, 7'h44, 7'h45, 7'h46, 7'h49};
    load_word("HANGMAN", 3'd7);
    for (int i = 0; i < 7; i++) begin
      guess_valid = 1'b1;
      guess_char  = misses[i];
      @(negedge clk);
      guess_valid = 1'b0;
      @(negedge clk);
      checks++; if (lives !== 3'(6 - i)) begin fails++; $display("FAIL miss_lives%0d: got %0d want %0d", i, lives, 6 - i); end
      checks++; if (reveal_mask !== 7'h00) begin fails++; $display("FAIL miss_mask%0d: got %h want 00", i, reveal_mask); end
      @(negedge clk);
    end
    checks++; if (lose !== 1'b1) begin fails++; $display("FAIL lose_flag: got %b want 1", lose); end
    checks++; if (guess_ready !== 1'b0) begin fails++; $display("FAIL lose_ready: got %b want 0", guess_ready); end
    guess_valid = 1'b1;
    guess_char  = 7'h48;
    @(negedge clk);
    guess_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (reveal_mask !== 7'h00) begin fails++; $display("FAIL lose_ignore_mask: got %h want 00", reveal_mask); end
    checks++; if ({lose, win, lives} !== 5'b10000) begin fails++; $display("FAIL lose_hold: got %b want 10000", {lose, win, lives}); end
  endtask

  task automatic test_win();
    load_word("HANGMAN", 3'd7);
    do_guess(7'h48);
    do_guess(7'h41);
    do_guess(7'h4E);
    do_guess(7'h47);
    checks++; if (reveal_mask !== 7'h6F) begin fails++; $display("FAIL win_partial: got %h want 6F", reveal_mask); end
    checks++; if (win !== 1'b0) begin fails++; $display("FAIL win_early: got %b want 0", win); end
    guess_valid = 1'b1;
    guess_char  = 7'h4D;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    checks++; if (reveal_mask !== 7'h7F) begin fails++; $display("FAIL win_mask: got %h want 7F", reveal_mask); end
    checks++; if (win !== 1'b0) begin fails++; $display("FAIL win_e1: got %b want 0", win); end
    @(negedge clk);
    checks++; if (win !== 1'b1) begin fails++; $display("FAIL win_e2: got %b want 1", win); end
    checks++; if (lives !== 3'd7) begin fails++; $display("FAIL win_lives: got %0d want 7", lives); end
    load_word("APPLE", 3'd5);
    do_guess(7'h41);
    do_guess(7'h50);
    do_guess(7'h4C);
    checks++; if (win !== 1'b0) begin fails++; $display("FAIL win5_early: got %b want 0", win); end
    do_guess(7'h45);
    checks++; if (reveal_mask !== 7'h1F) begin fails++; $display("FAIL win5_mask: got %h want 1F", reveal_mask); end
    checks++; if (win !== 1'b1) begin fails++; $display("FAIL win5_flag: got %b want 1", win); end
  endtask

  task automatic test_dup();
    load_word("HANGMAN", 3'd7);
    do_guess(7'h5A);
    guess_valid = 1'b1;
    guess_char  = 7'h5A;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
`ifdef HANGMAN_DUP_FILTER_EN
    checks++; if (guess_reject !== 1'b1) begin fails++; $display("FAIL dup_reject: got %b want 1", guess_reject); end
    checks++; if (lives !== 3'd6) begin fails++; $display("FAIL dup_lives: got %0d want 6", lives); end
`else
    checks++; if (guess_reject !== 1'b0) begin fails++; $display("FAIL dup_reject: got %b want 0", guess_reject); end
    checks++; if (lives !== 3'd5) begin fails++; $display("FAIL dup_lives: got %0d want 5", lives); end
`endif
    @(negedge clk);
    checks++; if (guess_ready !== 1'b1) begin fails++; $display("FAIL dup_ready: got %b want 1", guess_ready); end
  endtask

  task automatic test_illegal();
    logic [6:0] bad [3];
    bad = '{7'h31, 7'h40, 7'h5B};
    load_word("HANGMAN", 3'd7);
    do_guess(7'h41);
    for (int i = 0; i < 3; i++) begin
      guess_valid = 1'b1;
      guess_char  = bad[i];
      @(negedge clk);
      guess_valid = 1'b0;
      @(negedge clk);
      checks++; if (guess_reject !== 1'b1) begin fails++; $display("FAIL ill_reject%0d: got %b want 1", i, guess_reject); end
      checks++; if ({reveal_mask, lives} !== {7'h22, 3'd7}) begin
        fails++; $display("FAIL ill_state%0d: got %h/%0d want 22/7", i, reveal_mask, lives); end
      checks++; if (guess_ready !== 1'b1) begin fails++; $display("FAIL ill_ready%0d: got %b want 1", i, guess_ready); end
      @(negedge clk);
      checks++; if (guess_reject !== 1'b0) begin fails++; $display("FAIL ill_pulse%0d: got %b want 0", i, guess_reject); end
    end
  endtask

  task automatic test_word_req();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++; if (word_req !== 1'b1) begin fails++; $display("FAIL req_entry: got %b want 1", word_req); end
    @(negedge clk);
    checks++; if (word_req !== 1'b0) begin fails++; $display("FAIL req_pulse: got %b want 0", word_req); end
    word_valid = 1'b1;
    word_i     = mkword("HANGMAN");
    word_len   = 3'd0;
    @(negedge clk);
    word_valid = 1'b0;
    checks++; if ({word_req, guess_ready} !== 2'b10) begin fails++; $display("FAIL req_len0: got %b want 10", {word_req, guess_ready}); end
    @(negedge clk);
    checks++; if ({word_req, guess_ready} !== 2'b00) begin fails++; $display("FAIL req_len0_wait: got %b want 00", {word_req, guess_ready}); end
    word_valid = 1'b1;
    word_len   = 3'd7;
    @(negedge clk);
    word_valid = 1'b0;
    checks++; if (guess_ready !== 1'b1) begin fails++; $display("FAIL req_loaded: got %b want 1", guess_ready); end
  endtask

  task automatic test_new_game();
    load_word("HANGMAN", 3'd7);
    do_guess(7'h41);
    do_guess(7'h51);
    guess_valid = 1'b1;
    guess_char  = 7'h5A;
    @(negedge clk);
    guess_valid = 1'b0;
    new_game    = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++; if ({reveal_mask, lives} !== {7'h22, 3'd6}) begin
      fails++; $display("FAIL ng_check_drop: got %h/%0d want 22/6", reveal_mask, lives); end
    checks++; if ({word_req, guess_ready} !== 2'b10) begin fails++; $display("FAIL ng_check_load: got %b want 10", {word_req, guess_ready}); end
    word_valid = 1'b1;
    word_i     = mkword("HANGMAN");
    word_len   = 3'd7;
    @(negedge clk);
    word_valid = 1'b0;
    checks++; if ({reveal_mask, lives} !== {7'h00, 3'd7}) begin
      fails++; $display("FAIL ng_reload: got %h/%0d want 00/7", reveal_mask, lives); end
    do_guess(7'h5A);
    guess_valid = 1'b1;
    guess_char  = 7'h41;
    new_game    = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    new_game    = 1'b0;
    checks++; if ({word_req, guess_ready} !== 2'b10) begin fails++; $display("FAIL ng_same_load: got %b want 10", {word_req, guess_ready}); end
    repeat (3) @(negedge clk);
    checks++; if ({reveal_mask, lives} !== {7'h00, 3'd6}) begin
      fails++; $display("FAIL ng_same_drop: got %h/%0d want 00/6", reveal_mask, lives); end
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    checks++; if ({reveal_mask, lives, guess_ready} !== {7'h00, 3'd7, 1'b1}) begin
      fails++; $display("FAIL ng_same_reload: got %h/%0d/%b want 00/7/1", reveal_mask, lives, guess_ready); end
  endtask

  task automatic test_reset_mid_eval();
    load_word("HANGMAN", 3'd7);
    do_guess(7'h5A);
    guess_valid = 1'b1;
    guess_char  = 7'h48;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    checks++; if ({reveal_mask, lives} !== {7'h01, 3'd6}) begin
      fails++; $display("FAIL rme_pre: got %h/%0d want 01/6", reveal_mask, lives); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({reveal_mask, lives} !== {7'h00, 3'd7}) begin
      fails++; $display("FAIL rme_async: got %h/%0d want 00/7", reveal_mask, lives); end
    checks++; if ({win, lose, guess_ready, word_req, guess_reject} !== 5'b0) begin
      fails++; $display("FAIL rme_flags: got %b want 00000", {win, lose, guess_ready, word_req, guess_reject}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({guess_ready, reveal_mask} !== 8'h00) begin
      fails++; $display("FAIL rme_idle: got %b/%h want 0/00", guess_ready, reveal_mask); end
  endtask

  initial begin
    reset       = 1'b1;
    new_game    = 1'b0;
    word_valid  = 1'b0;
    word_i      = '0;
    word_len    = 3'd0;
    guess_valid = 1'b0;
    guess_char  = 7'h00;
    test_reset();
    test_hit();
    test_miss_lose();
    test_win();
    test_dup();
    test_illegal();
    test_word_req();
    test_new_game();
    test_reset_mid_eval();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
